// File: rtl/aes_inv_round_if.sv
// Bus bundle for one AES inverse round: request side (state, key, last) and result side.
interface aes_inv_round_if;
    localparam int unsigned STATE_W = 128;

    logic               valid;
    logic               last;
    logic [STATE_W-1:0] data_in;
    logic [STATE_W-1:0] round_key;
    logic               out_valid;
    logic [STATE_W-1:0] data_out;

    modport master (output valid, last, data_in, round_key, input out_valid, data_out);
    modport slave  (input valid, last, data_in, round_key, output out_valid, data_out);
endinterface

// File: rtl/aes_inv_round.sv
// Three-stage AES-128 inverse cipher round: capture, InvShiftRows+InvSubBytes,
// AddRoundKey+InvMixColumns (InvMixColumns skipped when last is set).
module aes_inv_round (
    input  logic           clk,
    input  logic           rst,
    aes_inv_round_if.slave bus
);
    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of a, 2a, 4a, 8a are summed (k = 9, b, d or e)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic logic [STATE_W-1:0] inv_mix(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[STATE_W-1-COL_W*c -: COL_W] = inv_mix_col(s[STATE_W-1-COL_W*c -: COL_W]);
        return o;
    endfunction

    // Row r rotates right by r, then each byte goes through the inverse S-box
    function automatic logic [STATE_W-1:0] inv_shift_sub(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[STATE_W-1-8*(4*c+r) -: 8] = INV_SBOX[s[STATE_W-1-8*(4*((c-r+4)%4)+r) -: 8]];
        return o;
    endfunction

    logic               v0, v1, last0, last1, out_v_q;
    logic [STATE_W-1:0] st0, key0, st1, key1, out_q;
    logic [STATE_W-1:0] s1_next, t2;

    assign s1_next = inv_shift_sub(st0);
    assign t2      = st1 ^ key1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            out_v_q <= 1'b0;
            last0   <= 1'b0;
            last1   <= 1'b0;
            st0     <= '0;
            key0    <= '0;
            st1     <= '0;
            key1    <= '0;
            out_q   <= '0;
        end else begin
            v0      <= bus.valid;
            v1      <= v0;
            out_v_q <= v1;
            if (bus.valid) begin
                st0   <= bus.data_in;
                key0  <= bus.round_key;
                last0 <= bus.last;
            end
            if (v0) begin
                st1   <= s1_next;
                key1  <= key0;
                last1 <= last0;
            end
            if (v1)
                out_q <= last1 ? t2 : inv_mix(t2);
        end
    end

    assign bus.out_valid = out_v_q;
    assign bus.data_out  = out_q;
endmodule

// File: tb/tb_aes_inv_round.sv
// Directed and model-based bench for aes_inv_round: 3-cycle latency, bubbles, reset, inversion.
module tb_aes_inv_round;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    aes_inv_round_if bus ();
    aes_inv_round dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [0:255][7:0] sbox_rom;
    logic              exp_v_q[$];
    logic [127:0]      exp_d_q[$];
    logic [127:0]      last_out;
    logic [127:0]      vin[2], vkey[2], vexp[2];
    logic              vlast[2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward round pieces used to build inputs whose inverse-round result is known
    function automatic logic [127:0] fwd_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox_rom[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    // One cycle of stimulus; the output checked after the edge belongs to the entry 3 cycles back
    task automatic drive(input logic v, input logic l, input logic [127:0] d,
                         input logic [127:0] k, input logic [127:0] e);
        logic         ev;
        logic [127:0] ed;
        bus.valid = v;
        bus.last = l;
        bus.data_in = d;
        bus.round_key = k;
        exp_v_q.push_back(v);
        exp_d_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_v_q.size() == 3) begin
            ev = exp_v_q.pop_front();
            ed = exp_d_q.pop_front();
            check("out_valid", 128'(bus.out_valid), 128'(ev));
            if (ev) last_out = ed;
            check("data_out", bus.data_out, last_out);
        end else begin
            check("fill_valid", 128'(bus.out_valid), 128'(0));
            check("fill_data", bus.data_out, last_out);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, rand128(), rand128(), '0);
    endtask

    // valid is held high alongside rst to confirm it is ignored
    task automatic apply_reset(input int n);
        rst = 1'b1;
        bus.valid = 1'b1;
        bus.last = 1'b0;
        bus.data_in = rand128();
        bus.round_key = rand128();
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_valid", 128'(bus.out_valid), 128'(0));
            check("rst_data", bus.data_out, '0);
        end
        rst = 1'b0;
        bus.valid = 1'b0;
        exp_v_q.delete();
        exp_d_q.delete();
        last_out = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x, k, y;
        logic         l, v;
        int           j;

        sbox_rom = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        vin[0]  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
        vkey[0] = 128'h549932d1f08557681093ed9cbe2c974e;
        vexp[0] = 128'h54d990a16ba09ab596bbf40ea111702f;
        vlast[0] = 1'b0;
        vin[1]  = 128'h6353e08c0960e104cd70b751bacad0e7;
        vkey[1] = 128'h000102030405060708090a0b0c0d0e0f;
        vexp[1] = 128'h00112233445566778899aabbccddeeff;
        vlast[1] = 1'b1;
        last_out = '0;
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.last = 1'b0;
        bus.data_in = '0;
        bus.round_key = '0;

        apply_reset(2);

        // FIPS-197 vectors, then InvMixColumns column checks with an all-zero sub-bytes result
        drive(1'b1, vlast[0], vin[0], vkey[0], vexp[0]);
        drive(1'b1, vlast[1], vin[1], vkey[1], vexp[1]);
        drive(1'b1, 1'b0, {16{8'h63}}, 128'h8e4da1bc_01010101_9fdc589d_c6c6c6c6,
              128'hdb135345_01010101_f20a225c_c6c6c6c6);
        drive(1'b1, 1'b1, {16{8'h63}}, 128'h8e4da1bc_01010101_9fdc589d_c6c6c6c6,
              128'h8e4da1bc_01010101_9fdc589d_c6c6c6c6);
        idle(3);

        for (int i = 0; i < 20; i++)
            drive(1'b1, vlast[i%2], vin[i%2], vkey[i%2], vexp[i%2]);
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            j = int'($urandom_range(0, 1));
            drive(v, vlast[j], vin[j], vkey[j], vexp[j]);
        end
        idle(3);

        // Reset with transactions in flight; nothing stale may emerge
        for (int i = 0; i < 3; i++)
            drive(1'b1, vlast[i%2], vin[i%2], vkey[i%2], vexp[i%2]);
        apply_reset(1);
        drive(1'b1, vlast[0], vin[0], vkey[0], vexp[0]);
        idle(3);

        // Forward-round-built inputs must invert back to the original state
        for (int i = 0; i < 1000; i++) begin
            x = rand128();
            k = rand128();
            l = ($urandom_range(0, 3) == 0);
            y = fwd_sub_shift((l ? x : fwd_mix(x)) ^ k);
            drive(1'b1, l, y, k, x);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
